// File: rtl/bkg_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : bkg_pixel_fetch
// Purpose  : Maps 640x480 VGA coordinates onto a 160x160 background RAM with
//            4x replication and a frame-synchronous wrap-around vertical scroll.
// Revision : 1.0 - initial release
// ============================================================================
module bkg_pixel_fetch #(
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 160,
    parameter int SCALE_SHIFT = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        pix_valid_in,
    input  logic        frame_start,
    input  logic [7:0]  scroll_in,
    input  logic        scroll_we,
    output logic [14:0] read_address,
    input  logic [23:0] ram_data,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic        pix_valid_out,
    output logic        scroll_pending
);

    localparam logic [8:0] c_img_h = 9'(IMG_H);
    localparam logic [9:0] c_scr_w = 10'(IMG_W << SCALE_SHIFT);
    localparam logic [9:0] c_scr_h = 10'(IMG_H * 3 << SCALE_SHIFT >> 2);

    logic [7:0]  r_scroll_cur;
    logic [7:0]  r_scroll_next;
    logic        r_v1;
    logic        r_v2;

    logic        w_qv;
    logic [7:0]  w_col;
    logic [7:0]  w_img_row;
    logic [8:0]  w_r;
    logic [7:0]  w_row;
    logic [14:0] w_addr;
    logic        w_scroll_ok;

    assign w_qv      = pix_valid_in && (DrawX < c_scr_w) && (DrawY < c_scr_h);
    assign w_col     = DrawX[SCALE_SHIFT +: 8];
    assign w_img_row = DrawY[SCALE_SHIFT +: 8];
    assign w_r       = {1'b0, w_img_row} + {1'b0, r_scroll_cur};

    // Both operands are below IMG_H for a qualified pixel, so one subtract wraps.
    assign w_row  = (w_r >= c_img_h) ? 8'(w_r - c_img_h) : w_r[7:0];

    // row*160 as row*128 + row*32.
    assign w_addr = {w_row, 7'b0} + {2'b0, w_row, 5'b0} + {7'b0, w_col};

    assign w_scroll_ok = ({1'b0, scroll_in} < c_img_h);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address   <= '0;
            r_v1           <= 1'b0;
            r_v2           <= 1'b0;
            Red            <= '0;
            Green          <= '0;
            Blue           <= '0;
            pix_valid_out  <= 1'b0;
            r_scroll_cur   <= '0;
            r_scroll_next  <= '0;
            scroll_pending <= 1'b0;
        end else begin
            read_address  <= w_qv ? w_addr : '0;
            r_v1          <= w_qv;
            r_v2          <= r_v1;
            {Red, Green, Blue} <= r_v2 ? ram_data : 24'h0;
            pix_valid_out <= r_v2;

            if (frame_start && scroll_pending) begin
                r_scroll_cur   <= r_scroll_next;
                scroll_pending <= 1'b0;
            end
            // A write in the same cycle as frame_start is held for the next frame.
            if (scroll_we && w_scroll_ok) begin
                r_scroll_next  <= scroll_in;
                scroll_pending <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bkg_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_bkg_pixel_fetch
// Purpose  : Randomized and directed self-checking bench for bkg_pixel_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bkg_pixel_fetch;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        pix_valid_in;
    logic        frame_start;
    logic [7:0]  scroll_in;
    logic        scroll_we;
    logic [14:0] read_address;
    logic [23:0] ram_data = 24'h0;
    logic [7:0]  Red;
    logic [7:0]  Green;
    logic [7:0]  Blue;
    logic        pix_valid_out;
    logic        scroll_pending;

    int tests = 0;
    int fails = 0;

    bkg_pixel_fetch dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .pix_valid_in   (pix_valid_in),
        .frame_start    (frame_start),
        .scroll_in      (scroll_in),
        .scroll_we      (scroll_we),
        .read_address   (read_address),
        .ram_data       (ram_data),
        .Red            (Red),
        .Green          (Green),
        .Blue           (Blue),
        .pix_valid_out  (pix_valid_out),
        .scroll_pending (scroll_pending)
    );

    always #5 Clk = ~Clk;

    function automatic logic [23:0] fmem(input logic [14:0] a);
        return {a[7:0] ^ 8'h5A, 1'b0, a};
    endfunction

    // Registered-read RAM: data appears one edge after the address.
    always @(posedge Clk) ram_data <= fmem(read_address);

    // Reference model: per-sample history plus the scroll registers.
    int hist_addr [4096];
    bit hist_v    [4096];
    int cyc;
    int m_cur, m_next;
    bit m_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_cur = 0; m_next = 0; m_pend = 0;
    endtask

    task automatic check_all();
        int k;
        logic [23:0] exp_rgb;
        bit exp_v;
        k = cyc - 3;
        exp_v   = (k >= 0) ? hist_v[k] : 1'b0;
        exp_rgb = exp_v ? fmem(15'(hist_addr[k])) : 24'h0;
        chk("read_address", 32'(read_address), 32'(hist_addr[cyc-1]));
        chk("rgb", 32'({Red, Green, Blue}), 32'(exp_rgb));
        chk("pix_valid_out", 32'(pix_valid_out), 32'(exp_v));
        chk("scroll_pending", 32'(scroll_pending), 32'(m_pend));
    endtask

    task automatic step(input int x, input int y, input bit v,
                        input bit fs, input bit we, input int s);
        bit qv;
        DrawX = 10'(x); DrawY = 10'(y); pix_valid_in = v;
        frame_start = fs; scroll_we = we; scroll_in = 8'(s);
        qv = v && (x < 640) && (y < 480);
        hist_v[cyc]    = qv;
        hist_addr[cyc] = qv ? (((y / 4) + m_cur) % 160) * 160 + (x / 4) : 0;
        if (fs && m_pend) begin m_cur = m_next; m_pend = 0; end
        if (we && s < 160) begin m_next = s; m_pend = 1; end
        @(posedge Clk); #1;
        cyc++;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, 32'(read_address), 0);
        chk({tag, "_rgb"}, 32'({Red, Green, Blue}), 0);
        chk({tag, "_vout"}, 32'(pix_valid_out), 0);
        chk({tag, "_pend"}, 32'(scroll_pending), 0);
    endtask

    initial begin
        Reset_n = 0; DrawX = 0; DrawY = 0; pix_valid_in = 0;
        frame_start = 0; scroll_in = 0; scroll_we = 0;
        model_reset();

        // Reset held while inputs toggle.
        for (int i = 0; i < 6; i++) begin
            DrawX = 10'($urandom_range(0, 639)); DrawY = 10'($urandom_range(0, 479));
            pix_valid_in = 1; frame_start = $urandom_range(0, 1);
            scroll_we = 1; scroll_in = 8'($urandom_range(0, 159));
            @(posedge Clk); #1;
            chk_zero("in_reset");
        end
        Reset_n = 1;

        // First pixel after reset.
        step(8, 4, 1, 0, 0, 0);
        chk("first_addr", 32'(read_address), 162);
        idle(2);
        chk("first_rgb", 32'({Red, Green, Blue}), 32'(fmem(15'd162)));
        chk("first_vout", 32'(pix_valid_out), 1);

        // Full line sweep at row 0.
        for (int x = 0; x < 640; x++) step(x, 0, 1, 0, 0, 0);
        idle(3);

        // Wrap with scroll 150.
        step(0, 0, 0, 0, 1, 150);
        chk("pend_150", 32'(scroll_pending), 1);
        step(0, 0, 0, 1, 0, 0);
        step(0, 40, 1, 0, 0, 0);
        chk("wrap_160", 32'(read_address), 0);
        step(636, 476, 1, 0, 0, 0);
        chk("wrap_269", 32'(read_address), 17599);
        idle(3);

        // Scroll 159 boundary.
        step(0, 0, 0, 0, 1, 159);
        step(0, 0, 0, 1, 0, 0);
        step(12, 0, 1, 0, 0, 0);
        chk("wrap159_row0", 32'(read_address), 159 * 160 + 3);
        step(12, 4, 1, 0, 0, 0);
        chk("wrap159_row1", 32'(read_address), 3);

        // Mid-frame write held until frame_start; out-of-range write ignored.
        step(0, 0, 0, 0, 1, 10);
        step(0, 8, 1, 0, 0, 0);
        chk("held_addr", 32'(read_address), ((2 + 159) % 160) * 160);
        step(0, 0, 0, 1, 0, 0);
        chk("applied_pend", 32'(scroll_pending), 0);
        step(0, 8, 1, 0, 0, 0);
        chk("applied_addr", 32'(read_address), 12 * 160);
        step(0, 0, 0, 0, 1, 200);
        chk("ignored_pend", 32'(scroll_pending), 0);
        step(0, 8, 1, 0, 0, 0);
        chk("ignored_addr", 32'(read_address), 12 * 160);

        // Write coinciding with frame_start.
        step(0, 0, 0, 0, 1, 20);
        step(0, 0, 0, 1, 1, 30);
        chk("simul_pend", 32'(scroll_pending), 1);
        step(0, 0, 1, 0, 0, 0);
        chk("simul_cur20", 32'(read_address), 20 * 160);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("simul_cur30", 32'(read_address), 30 * 160);

        // Invalid region.
        step(700, 10, 1, 0, 0, 0);
        chk("inv_x_addr", 32'(read_address), 0);
        step(100, 10, 0, 0, 0, 0);
        step(100, 500, 1, 0, 0, 0);
        step(4, 4, 1, 0, 0, 0);
        chk("inv_x_vout", 32'(pix_valid_out), 0);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 700), $urandom_range(0, 520),
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 15) == 0), $urandom_range(0, 255));

        // Asynchronous reset mid-line.
        for (int i = 0; i < 5; i++) step(40 + 4 * i, 100, 1, 0, 0, 0);
        Reset_n = 0;
        #1;
        chk_zero("async_rst");
        model_reset();
        @(posedge Clk); #1;
        Reset_n = 1;
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 700), $urandom_range(0, 520),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 30) == 0),
                 ($urandom_range(0, 10) == 0), $urandom_range(0, 255));
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bkg_pixel_fetch.md
Name: bkg_pixel_fetch

Overview:
Read-side client of the 160x160, 24-bit background RAM (15-bit read address, 1-cycle registered read data). Maps VGA DrawX/DrawY (640x480) onto the image with 4x pixel replication and a wrap-around vertical scroll offset, then drives the RAM read address. Returns pipelined RGB aligned with a delayed valid flag for the color mapper. Scroll updates are latched and applied only at frame boundaries to avoid tearing.

Parameters:
IMG_W, 160, image width in pixels
IMG_H, 160, image height in rows; the scroll wrap modulus
SCALE_SHIFT, 2, log2 of the screen-to-image scale factor (both axes)

Ports:
Clk  in  1  system clock; all state on rising edge
Reset_n  in  1  asynchronous active-low reset
DrawX  in  10  current screen column
DrawY  in  10  current screen row
pix_valid_in  in  1  high while the screen pixel is in the active region
frame_start  in  1  one-cycle pulse at the start of vertical blank
scroll_in  in  8  requested vertical scroll offset, in image rows
scroll_we  in  1  one-cycle write strobe for scroll_in
read_address  out  15  background RAM read address
ram_data  in  24  RAM read data {R[23:16],G[15:8],B[7:0]}, valid 1 cycle after the address
Red  out  8  pixel red
Green  out  8  pixel green
Blue  out  8  pixel blue
pix_valid_out  out  1  pix_valid_in delayed 3 cycles, qualified
scroll_pending  out  1  a scroll value is latched and waiting for frame_start

Behaviour:
- Reset (Reset_n low, asynchronous): read_address=0, Red/Green/Blue=0, pix_valid_out=0, scroll_pending=0, scroll_cur=0, scroll_next=0, all pipeline registers 0. Deasserting reset mid-frame resumes output from the next qualified sample.
- Qualification: qv = pix_valid_in & (DrawX<640) & (DrawY<480). If qv=0, treat the pixel as invalid.
- Stage 1, address, edge n+1:
  - col = DrawX>>SCALE_SHIFT (0..159).
  - r = (DrawY>>SCALE_SHIFT) + scroll_cur (9-bit sum, max 278).
  - row = r - IMG_H when r >= IMG_H, else row = r. Use a single conditional subtract; no divider.
  - addr = row*160 + col, computed as (row<<7)+(row<<5)+col with no multiplier. Range 0..25599.
  - read_address <= qv ? addr : 0.
  - v1 <= qv.
- Stage 2, RAM, edge n+2: the RAM presents ram_data for the address. v2 <= v1.
- Stage 3, output, edge n+3:
  - {Red,Green,Blue} <= v2 ? ram_data : 24'h0.
  - pix_valid_out <= v2.
- Total latency: DrawX/DrawY sample to RGB is 3 cycles. Throughput is 1 pixel/cycle with no stalls.
- Scroll latch:
  - On scroll_we with scroll_in < IMG_H: scroll_next <= scroll_in and scroll_pending <= 1.
  - On scroll_we with scroll_in >= IMG_H: the write is ignored; state is unchanged.
  - Back-to-back writes: the last valid write before frame_start wins.
- Scroll apply: on frame_start with scroll_pending=1, scroll_cur <= scroll_next and scroll_pending <= 0. On frame_start with scroll_pending=0, nothing changes.
- Simultaneous scroll_we (valid) and frame_start:
  - scroll_cur takes the previously latched scroll_next, but only if scroll_pending was already 1.
  - scroll_next then takes the new value and scroll_pending ends at 1.
  - The new value applies at the following frame_start.
- scroll_cur changes only on frame_start. Pixels already in the pipeline complete with their computed address.
- Wrap boundary:
  - scroll_cur=159, image row 0 maps to RAM row 159.
  - Image row 1 maps to RAM row 0 (address col+0).
- All arithmetic is unsigned. No addresses are produced outside 0..25599.

Test Plan:
- Reset: hold Reset_n=0 and toggle all inputs -> all outputs 0. Release, drive DrawX=8, DrawY=4, pix_valid_in=1 -> read_address=162 after 1 edge, RGB=ram_data after 3 edges, pix_valid_out=1.
- Pipeline alignment: model the RAM as mem[a]=a, sweep DrawX 0..639 on DrawY=0 -> RGB sequence 0,0,0,0,1,1,1,1,...,159 with 3-cycle lag, no gaps or duplicates.
- Wrap: write scroll_in=150, pulse frame_start, then DrawY=40 (r=160), DrawX=0 -> read_address=0. DrawY=476 (r=269), DrawX=636 -> read_address=109*160+159=17599.
- Scroll timing: scroll_we=10 mid-frame -> scroll_pending=1 and addresses unchanged until frame_start, after which row offset=10 and scroll_pending=0. Write 200 -> ignored, scroll_pending stays 0.
- Simultaneous events: scroll_we=20, then scroll_we=30 in the same cycle as frame_start -> scroll_cur=20 and scroll_pending=1. The next frame_start gives scroll_cur=30.
- Invalid region: pix_valid_in=1 with DrawX=700, or pix_valid_in=0 -> read_address=0 next cycle, RGB=0 and pix_valid_out=0 three cycles later. Assert Reset_n=0 mid-line -> outputs 0 immediately, asynchronously.
